// File: rtl/if_id_fetch.sv
// MIPS32 instruction-fetch stage with IF/ID pipeline register: PC, imem address, stall/redirect/wait handling.
// Optional flush/stall event counters are built when IF_ID_STATS_EN is defined.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal fetch, or a bubble while imem_ready is low
// HOLD     | stall asserted; PC and IF/ID contents frozen
// REDIRECT | cycle after branch_taken; IF/ID holds the flush bubble
module if_id_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [5:0]  id_opcode,
  output logic [31:0] id_pc_plus4
`ifdef IF_ID_STATS_EN
  ,
  output logic [15:0] stat_flush_cnt,
  output logic [15:0] stat_stall_cnt
`endif
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_HOLD     = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  logic [31:0] r_pc;
  logic        r_id_valid;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc_plus4;
  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [31:0] w_pc_plus4;
  logic        w_unused_tgt;

  assign w_pc_plus4   = r_pc + 32'd4;
  // Branch targets are word-aligned by dropping the low two bits.
  assign w_unused_tgt = ^branch_target[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_id_valid    <= 1'b0;
      r_id_instr    <= NOP_INSTR;
      r_id_pc_plus4 <= 32'h0000_0000;
    end else if (branch_taken) begin
      r_pc       <= {branch_target[31:2], 2'b00};
      r_id_valid <= 1'b0;
      r_id_instr <= NOP_INSTR;
    end else if (stall) begin
      r_pc <= r_pc;
    end else if (!imem_ready) begin
      r_id_valid <= 1'b0;
      r_id_instr <= NOP_INSTR;
    end else begin
      r_id_instr    <= imem_rdata;
      r_id_pc_plus4 <= w_pc_plus4;
      r_id_valid    <= 1'b1;
      r_pc          <= w_pc_plus4;
    end
  end

  always_comb begin
    w_next_state = ST_RUN;
    case (r_state)
      ST_HOLD: begin
        if (branch_taken)  w_next_state = ST_REDIRECT;
        else if (stall)    w_next_state = ST_HOLD;
        else               w_next_state = ST_RUN;
      end
      ST_REDIRECT: begin
        if (branch_taken)  w_next_state = ST_REDIRECT;
        else if (stall)    w_next_state = ST_HOLD;
        else               w_next_state = ST_RUN;
      end
      default: begin
        if (branch_taken)  w_next_state = ST_REDIRECT;
        else if (stall)    w_next_state = ST_HOLD;
        else               w_next_state = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_next_state;
  end

  assign imem_addr   = r_pc;
  assign id_valid    = r_id_valid;
  assign id_instr    = r_id_instr;
  assign id_opcode   = r_id_instr[31:26];
  assign id_pc_plus4 = r_id_pc_plus4;

`ifdef IF_ID_STATS_EN
  logic [15:0] r_flush_cnt;
  logic [15:0] r_stall_cnt;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_cnt <= 16'h0000;
      r_stall_cnt <= 16'h0000;
    end else begin
      if (branch_taken && (r_flush_cnt != 16'hFFFF))
        r_flush_cnt <= r_flush_cnt + 16'd1;
      if (stall && !branch_taken && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stat_flush_cnt = r_flush_cnt;
  assign stat_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_if_id_fetch.sv
// Directed, table-driven bench for if_id_fetch: reset, fetch, stall, redirect, wait states, PC wrap, async reset.
// Counter checks are compiled in when IF_ID_STATS_EN is defined.
module tb_if_id_fetch;

  typedef struct packed {
    logic        stall;
    logic        branch;
    logic [31:0] tgt;
    logic        ready;
    logic [31:0] rdata;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic [31:0] e_addr;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [5:0]  id_opcode;
  logic [31:0] id_pc_plus4;
`ifdef IF_ID_STATS_EN
  logic [15:0] stat_flush_cnt;
  logic [15:0] stat_stall_cnt;
`endif

  int tests = 0;
  int fails = 0;
  vec_t vecs[$];

  if_id_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_opcode     (id_opcode),
    .id_pc_plus4   (id_pc_plus4)
`ifdef IF_ID_STATS_EN
    ,
    .stat_flush_cnt(stat_flush_cnt),
    .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_valid, input logic [31:0] e_instr,
                         input logic [31:0] e_pc4, input logic [31:0] e_addr);
    logic [31:0] e_op;
    e_op = {26'd0, e_instr[31:26]};
    chk({tag, ".valid"},  {31'd0, id_valid}, {31'd0, e_valid});
    chk({tag, ".instr"},  id_instr, e_instr);
    chk({tag, ".opcode"}, {26'd0, id_opcode}, e_op);
    chk({tag, ".pc4"},    id_pc_plus4, e_pc4);
    chk({tag, ".addr"},   imem_addr, e_addr);
  endtask

  task automatic add(input logic s, input logic b, input logic [31:0] t, input logic r,
                     input logic [31:0] d, input logic ev, input logic [31:0] ei,
                     input logic [31:0] ep, input logic [31:0] ea);
    vec_t v;
    v = '{stall: s, branch: b, tgt: t, ready: r, rdata: d,
          e_valid: ev, e_instr: ei, e_pc4: ep, e_addr: ea};
    vecs.push_back(v);
  endtask

  initial begin
    //   stall br  target        rdy rdata          valid instr          pc4            addr
    add(0, 0, 32'h0,         1, 32'h8C010004, 1, 32'h8C010004, 32'h00000004, 32'h00000004);
    add(0, 0, 32'h0,         1, 32'h00221820, 1, 32'h00221820, 32'h00000008, 32'h00000008);
    add(1, 0, 32'h0,         1, 32'hDEADBEEF, 1, 32'h00221820, 32'h00000008, 32'h00000008);
    add(1, 0, 32'h0,         1, 32'hDEADBEEF, 1, 32'h00221820, 32'h00000008, 32'h00000008);
    add(1, 0, 32'h0,         1, 32'hDEADBEEF, 1, 32'h00221820, 32'h00000008, 32'h00000008);
    add(0, 0, 32'h0,         1, 32'hAC030008, 1, 32'hAC030008, 32'h0000000C, 32'h0000000C);
    add(1, 1, 32'h00000043,  1, 32'h11111111, 0, 32'h00000000, 32'h0000000C, 32'h00000040);
    add(0, 0, 32'h0,         1, 32'h24040001, 1, 32'h24040001, 32'h00000044, 32'h00000044);
    add(0, 1, 32'h00000010,  1, 32'h22222222, 0, 32'h00000000, 32'h00000044, 32'h00000010);
    add(0, 0, 32'h0,         0, 32'hFFFFFFFF, 0, 32'h00000000, 32'h00000044, 32'h00000010);
    add(0, 0, 32'h0,         0, 32'hFFFFFFFF, 0, 32'h00000000, 32'h00000044, 32'h00000010);
    add(0, 0, 32'h0,         1, 32'h3C05ABCD, 1, 32'h3C05ABCD, 32'h00000014, 32'h00000014);
    add(0, 1, 32'hFFFFFFFE,  1, 32'h33333333, 0, 32'h00000000, 32'h00000014, 32'hFFFFFFFC);
    add(0, 0, 32'h0,         1, 32'h08000000, 1, 32'h08000000, 32'h00000000, 32'h00000000);
    add(0, 1, 32'h00000020,  0, 32'h44444444, 0, 32'h00000000, 32'h00000000, 32'h00000020);
    add(0, 1, 32'h00000024,  1, 32'h55555555, 0, 32'h00000000, 32'h00000000, 32'h00000024);
    add(1, 0, 32'h0,         0, 32'h66666666, 0, 32'h00000000, 32'h00000000, 32'h00000024);
    add(0, 0, 32'h0,         1, 32'h8FBF0010, 1, 32'h8FBF0010, 32'h00000028, 32'h00000028);

    rst_n         = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    imem_ready    = 1'b1;
    imem_rdata    = 32'h8C010004;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 32'h0, 32'h0, 32'h0);
`ifdef IF_ID_STATS_EN
    chk("reset.flush_cnt", {16'd0, stat_flush_cnt}, 32'd0);
    chk("reset.stall_cnt", {16'd0, stat_stall_cnt}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      stall         = vecs[i].stall;
      branch_taken  = vecs[i].branch;
      branch_target = vecs[i].tgt;
      imem_ready    = vecs[i].ready;
      imem_rdata    = vecs[i].rdata;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_instr,
              vecs[i].e_pc4, vecs[i].e_addr);
    end

`ifdef IF_ID_STATS_EN
    chk("stats.flush_cnt", {16'd0, stat_flush_cnt}, 32'd5);
    chk("stats.stall_cnt", {16'd0, stat_stall_cnt}, 32'd4);
`endif

    // Async reset in the middle of a stall, well away from any clock edge.
    stall        = 1'b1;
    branch_taken = 1'b0;
    imem_ready   = 1'b1;
    imem_rdata   = 32'h77777777;
    repeat (2) @(posedge clk);
    #1;
    chk_all("prestall", 1'b1, 32'h8FBF0010, 32'h00000028, 32'h00000028);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("midstall_rst", 1'b0, 32'h0, 32'h0, 32'h0);
`ifdef IF_ID_STATS_EN
    chk("midstall_rst.flush_cnt", {16'd0, stat_flush_cnt}, 32'd0);
    chk("midstall_rst.stall_cnt", {16'd0, stat_stall_cnt}, 32'd0);
`endif
    @(posedge clk);
    #1;
    chk_all("held_in_rst", 1'b0, 32'h0, 32'h0, 32'h0);
    #2;
    rst_n      = 1'b1;
    stall      = 1'b0;
    imem_rdata = 32'h8C010004;
    @(posedge clk);
    #1;
    chk_all("after_rst", 1'b1, 32'h8C010004, 32'h00000004, 32'h00000004);

    // Async reset one cycle after a redirect.
    branch_taken  = 1'b1;
    branch_target = 32'h00000100;
    @(posedge clk);
    #1;
    branch_taken = 1'b0;
    chk_all("redir", 1'b0, 32'h0, 32'h00000004, 32'h00000100);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("midredir_rst", 1'b0, 32'h0, 32'h0, 32'h0);
    #2;
    rst_n      = 1'b1;
    imem_rdata = 32'h00851020;
    @(posedge clk);
    #1;
    chk_all("after_rst2", 1'b1, 32'h00851020, 32'h00000004, 32'h00000004);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
